// File: rtl/line_buf_pkg.sv
// Shared definitions for the multi-line window buffer.
//   PIX_W_DEF : default pixel width used by the buffer and its line RAMs
//   lb_clog2  : ceil(log2(n)), at least 1; sizes the row-fill counter
package line_buf_pkg;

  localparam int PIX_W_DEF = 16;

  function automatic int lb_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/line_ram.sv
// Single-clock simple dual-port line memory with a registered read port.
//   clk_i   : clock
//   we_i    : write enable, waddr_i / wdata_i : write port
//   re_i    : read enable,  raddr_i : read address
//   rdata_o : read data, one cycle after re_i; holds while re_i is low
// A read and a write to the same address in one cycle return the old data.
module line_ram
  import line_buf_pkg::*;
#(
  parameter int DATA_W = PIX_W_DEF,
  parameter int ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_window_buf.sv
// Multi-line window buffer: for every accepted raster pixel it presents a
// vertical column of LINES taps (current pixel plus the same column of the
// previous LINES-1 lines), one cycle after the pixel.
//   clk, rstn           : pixel clock, asynchronous active-low reset
//   frame_start         : restarts column/row tracking and clears overflow
//   pix_valid/pix_data  : pixel strobe and value
//   line_end            : last pixel of a line (qualified by pix_valid)
//   taps                : slice k = pixel k lines above; slice 0 = current
//   tap_valid/win_valid : taps valid / window fully inside current frame
//   tap_col, tap_last   : column and line_end of the presented taps
//   overflow            : sticky, a line ran past 2**ADDR_WIDTH pixels
module line_window_buf
  import line_buf_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_W_DEF,
  parameter int ADDR_WIDTH = 11,
  parameter int LINES      = 3
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        frame_start,
  input  logic                        pix_valid,
  input  logic [DATA_WIDTH-1:0]       pix_data,
  input  logic                        line_end,
  output logic [LINES*DATA_WIDTH-1:0] taps,
  output logic                        tap_valid,
  output logic                        win_valid,
  output logic [ADDR_WIDTH-1:0]       tap_col,
  output logic                        tap_last,
  output logic                        overflow
);

  localparam int NRAM = LINES - 1;
  localparam int RW   = lb_clog2(LINES);
  localparam logic [ADDR_WIDTH-1:0] COL_MAX   = '1;
  localparam logic [RW-1:0]         ROWS_FULL = RW'(LINES - 1);

  logic [ADDR_WIDTH-1:0] col_q, col_d, col_cur;
  logic [RW-1:0]         rows_q, rows_d, rows_cur;
  logic                  ovl_line_q, ovl_line_d, ovl_cur;
  logic                  overflow_q, overflow_d;

  logic                  tap_vld_q, win_q, tap_last_q, wr_ok_q, rd_seen_q, byp_q;
  logic [ADDR_WIDTH-1:0] tap_col_q;
  logic [DATA_WIDTH-1:0] pix_q;
  logic                  we;

  logic [NRAM-1:0][DATA_WIDTH-1:0] ram_rd, line_out, wdata;

  // ---- Input stage: column / row tracking for the pixel being accepted ----
  // frame_start acts on the same cycle, so a coincident pixel is col 0 row 0.
  always_comb begin
    col_cur    = frame_start ? '0 : col_q;
    rows_cur   = frame_start ? '0 : rows_q;
    ovl_cur    = frame_start ? 1'b0 : ovl_line_q;
    col_d      = col_cur;
    rows_d     = rows_cur;
    ovl_line_d = ovl_cur;
    overflow_d = frame_start ? 1'b0 : overflow_q;
    if (pix_valid) begin
      if (line_end) begin
        col_d      = '0;
        ovl_line_d = 1'b0;
        if (rows_cur != ROWS_FULL) rows_d = rows_cur + 1'b1;
      end else if (col_cur == COL_MAX) begin
        // Column holds at the last address; later pixels of this line are
        // presented but never stored.
        ovl_line_d = 1'b1;
        overflow_d = 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q      <= '0;
      rows_q     <= '0;
      ovl_line_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      rows_q     <= rows_d;
      ovl_line_q <= ovl_line_d;
      overflow_q <= overflow_d;
    end
  end

  // ---- Output stage: registered pixel, column and flags; RAM reads land here ----
  // byp_q marks a read that collided with the cascade write of the previous
  // pixel (1-pixel line followed by col 0); the written data is used instead.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tap_vld_q  <= 1'b0;
      win_q      <= 1'b0;
      tap_last_q <= 1'b0;
      tap_col_q  <= '0;
      wr_ok_q    <= 1'b0;
      rd_seen_q  <= 1'b0;
      byp_q      <= 1'b0;
      pix_q      <= '0;
    end else begin
      tap_vld_q  <= pix_valid;
      win_q      <= pix_valid && (rows_cur == ROWS_FULL);
      tap_last_q <= pix_valid && line_end;
      if (pix_valid) begin
        tap_col_q <= col_cur;
        wr_ok_q   <= !ovl_cur;
        rd_seen_q <= 1'b1;
        byp_q     <= we && (tap_col_q == col_cur);
        pix_q     <= pix_data;
      end
    end
  end

  // Cascade write happens one cycle after the read of the same column.
  assign we       = tap_vld_q && wr_ok_q;
  assign wdata[0] = pix_q;

  for (genvar j = 0; j < NRAM; j++) begin : g_ram
    logic [DATA_WIDTH-1:0] byp_data_q;

    line_ram #(
      .DATA_W(DATA_WIDTH),
      .ADDR_W(ADDR_WIDTH)
    ) u_ram (
      .clk_i  (clk),
      .we_i   (we),
      .waddr_i(tap_col_q),
      .wdata_i(wdata[j]),
      .re_i   (pix_valid),
      .raddr_i(col_cur),
      .rdata_o(ram_rd[j])
    );

    always_ff @(posedge clk) begin
      if (pix_valid) byp_data_q <= wdata[j];
    end

    // RAM read registers have no reset; mask them until the first read.
    assign line_out[j] = !rd_seen_q ? '0 : (byp_q ? byp_data_q : ram_rd[j]);

    if (j > 0) begin : g_casc
      assign wdata[j] = line_out[j-1];
    end
  end

  assign taps      = {line_out, pix_q};
  assign tap_valid = tap_vld_q;
  assign win_valid = win_q;
  assign tap_col   = tap_col_q;
  assign tap_last  = tap_last_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_line_window_buf.sv
module tb_line_window_buf;

  localparam int DW = 16;
  localparam int AW = 2;
  localparam int LN = 3;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic frame_start = 1'b0;
  logic pix_valid = 1'b0;
  logic line_end = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic [LN*DW-1:0] taps;
  logic tap_valid, win_valid, tap_last, overflow;
  logic [AW-1:0] tap_col;

  line_window_buf #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LINES     (LN)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .frame_start(frame_start),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .line_end   (line_end),
    .taps       (taps),
    .tap_valid  (tap_valid),
    .win_valid  (win_valid),
    .tap_col    (tap_col),
    .tap_last   (tap_last),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LN*DW-1:0] taps;
    logic [LN-1:0]    mask;
    logic [AW-1:0]    col;
    logic             last;
    logic             win;
    logic             ovf_chk;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_err = 0;

  // Column history: what a correct buffer holds one and two lines above.
  logic [DW-1:0] h1[NC], h2[NC];
  logic          k1[NC], k2[NC];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per presented tap column.
  always @(negedge clk) begin
    if (tap_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_tap: tap_valid=1 col=%0d with nothing expected", tap_col);
      end else begin
        mon_e = sb.pop_front();
        for (int k = 0; k < LN; k++)
          if (mon_e.mask[k])
            chk($sformatf("taps[%0d]", k), 64'(taps[k*DW +: DW]), 64'(mon_e.taps[k*DW +: DW]));
        chk("tap_col", 64'(tap_col), 64'(mon_e.col));
        chk("tap_last", 64'(tap_last), 64'(mon_e.last));
        chk("win_valid", 64'(win_valid), 64'(mon_e.win));
        if (mon_e.ovf_chk) chk("overflow", 64'(overflow), 64'(mon_e.ovf));
      end
    end
  end

  // Drive one pixel for one clock; ovf_e < 0 leaves overflow unchecked.
  task automatic px(input logic fs, input logic [DW-1:0] d, input logic le,
                    input int c, input logic win_e, input int ovf_e, input logic wr);
    exp_t e;
    e.taps = '0;
    e.mask = '0;
    e.taps[DW-1:0]      = d;     e.mask[0] = 1'b1;
    e.taps[DW +: DW]    = h1[c]; e.mask[1] = k1[c];
    e.taps[2*DW +: DW]  = h2[c]; e.mask[2] = k2[c];
    e.col     = c[AW-1:0];
    e.last    = le;
    e.win     = win_e;
    e.ovf_chk = (ovf_e >= 0);
    e.ovf     = (ovf_e == 1);
    sb.push_back(e);
    if (wr) begin
      h2[c] = h1[c]; k2[c] = k1[c];
      h1[c] = d;     k1[c] = 1'b1;
    end
    frame_start = fs;
    pix_valid   = 1'b1;
    pix_data    = d;
    line_end    = le;
    @(posedge clk); #1;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    line_end    = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_taps"}, 64'(taps), 64'd0);
    chk({tag, "_tap_valid"}, 64'(tap_valid), 64'd0);
    chk({tag, "_win_valid"}, 64'(win_valid), 64'd0);
    chk({tag, "_tap_col"}, 64'(tap_col), 64'd0);
    chk({tag, "_tap_last"}, 64'(tap_last), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    for (int c = 0; c < NC; c++) begin
      h1[c] = '0; h2[c] = '0; k1[c] = 1'b0; k2[c] = 1'b0;
    end
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    // Frame A: rows 0,1 full and row 2 cols 0..1, pixel = row*16+col,
    // then frame_start mid-row into frame B (0x80+row*16+col), no gaps.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        if (!(r == 2 && c > 1))
          px(r == 0 && c == 0, 16'(r*16 + c), c == 3, c, r == 2, 0, 1'b1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        px(r == 0 && c == 0, 16'(8'h80 + r*16 + c), c == 3, c, r == 2, 0, 1'b1);

    // Over-length line: 6 pixels into 4 columns, then a normal line.
    for (int i = 0; i < 6; i++)
      px(i == 0, 16'(8'h40 + i), i == 5, (i < 4) ? i : 3, 1'b0,
         (i < 3) ? 0 : ((i == 3) ? -1 : 1), i < 4);
    for (int c = 0; c < 4; c++)
      px(1'b0, 16'(8'h50 + c), c == 3, c, 1'b0, 1, 1'b1);

    // Back-to-back single-pixel lines 5,6,7; frame_start clears overflow.
    px(1'b1, 16'd5, 1'b1, 0, 1'b0, 0, 1'b1);
    px(1'b0, 16'd6, 1'b1, 0, 1'b0, 0, 1'b1);
    px(1'b0, 16'd7, 1'b1, 0, 1'b1, 0, 1'b1);

    // Reset in the middle of line 1.
    for (int c = 0; c < 4; c++)
      px(c == 0, 16'(8'h60 + c), c == 3, c, 1'b0, 0, 1'b1);
    px(1'b0, 16'h0064, 1'b0, 0, 1'b0, 0, 1'b1);
    px(1'b0, 16'h0065, 1'b0, 1, 1'b0, 0, 1'b1);
    @(negedge clk); #2;
    rstn = 1'b0;
    #1;
    chk_all_zero("async_rst");
    for (int c = 0; c < NC; c++) begin
      k1[c] = 1'b0; k2[c] = 1'b0;
    end
    @(posedge clk); @(posedge clk); #1;
    chk_all_zero("in_rst");
    rstn = 1'b1;
    @(posedge clk); #1;
    px(1'b0, 16'h0070, 1'b1, 0, 1'b0, 0, 1'b1);
    px(1'b0, 16'h0071, 1'b1, 0, 1'b0, 0, 1'b1);
    px(1'b0, 16'h0072, 1'b1, 0, 1'b1, 0, 1'b1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected tap outputs never appeared, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
